mux_pipe_n: RTL

- Parametrised N-input, W-bit multiplexer with a registered output stage and a valid/ready handshake on both sides.
- Includes a one-entry skid buffer so full throughput is sustained under output backpressure.
- Used in the SISC datapath wherever operand/result selection must be pipelined, e.g. register-file read select and writeback select.
- Out-of-range select values are flagged rather than silently aliased.

---
 rtl/mux_pipe_n.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: N-input, WIDTH-bit multiplexer with a registered output stage,
// valid/ready handshakes on both sides and a one-entry skid buffer.
//
// The select is decoded combinationally on the input side. The chosen word
// then enters a two-entry pipe made of the output register (O) and a skid
// register (S). S only fills when O is held by backpressure. Because of S,
// in_ready can be a pure function of state and still sustain one word per
// cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_bus     packed inputs; input i is in_bus[i*WIDTH +: WIDTH]
//   sel        input index, sampled together with in_valid
//   in_valid   upstream offers an (in_bus, sel) pair
//   in_ready   block can accept a pair this cycle (registered)
//   out        selected data, registered
//   out_err    word on out came from an out-of-range select
//   out_valid  out/out_err hold a valid word
//   out_ready  downstream takes the word this cycle
module mux_pipe_n #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    generate
        if (NUM_IN < 2 || (1 << SEL_W) < NUM_IN) begin : g_param_check
            $error("mux_pipe_n: need NUM_IN >= 2 and 2**SEL_W >= NUM_IN");
        end
    endgenerate

    // Unpack the bus into one word per input.
    logic [WIDTH-1:0] in_words [NUM_IN];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_split
            assign in_words[gi] = in_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Select decode. An out-of-range select yields zero data and err=1; the
    // explicit compare against every legal index means no modulo aliasing.
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    always_comb begin
        sel_data = '0;
        sel_err  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (int'(sel) == i) begin
                sel_data = in_words[i];
                sel_err  = 1'b0;
            end
        end
    end

    // Output register O and skid register S.
    logic [WIDTH-1:0] o_data_reg;
    logic             o_err_reg;
    logic             o_valid_reg;
    logic [WIDTH-1:0] s_data_reg;
    logic             s_err_reg;
    logic             s_valid_reg;

    logic in_xfer;
    logic out_xfer;
    logic o_free;

    assign in_ready = !s_valid_reg;
    assign in_xfer  = in_valid && !s_valid_reg;
    assign out_xfer = o_valid_reg && out_ready;
    // O may take a new word when it is empty or its word leaves this edge.
    assign o_free   = !o_valid_reg || out_xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data_reg  <= '0;
            o_err_reg   <= 1'b0;
            o_valid_reg <= 1'b0;
            s_data_reg  <= '0;
            s_err_reg   <= 1'b0;
            s_valid_reg <= 1'b0;
        end else if (o_free) begin
            if (s_valid_reg) begin
                // Oldest word moves from S to O. in_ready is low here, so
                // no input transfer can happen and S simply drains.
                o_data_reg  <= s_data_reg;
                o_err_reg   <= s_err_reg;
                o_valid_reg <= 1'b1;
                s_valid_reg <= 1'b0;
            end else begin
                o_valid_reg <= in_xfer;
                // Data only updates on a load so out keeps its last value
                // while the pipe is empty.
                if (in_xfer) begin
                    o_data_reg <= sel_data;
                    o_err_reg  <= sel_err;
                end
            end
        end else if (in_xfer) begin
            // O is stalled; park the incoming word in S.
            s_data_reg  <= sel_data;
            s_err_reg   <= sel_err;
            s_valid_reg <= 1'b1;
        end
    end

    assign out       = o_data_reg;
    assign out_err   = o_err_reg;
    assign out_valid = o_valid_reg;

endmodule
